// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and helpers for the regfile_sb register file.
//   DATA_W_DEF / NREGS_DEF : default data width and register count.
//   byte_merge(old, new, be): per-byte merge; lane k takes new when be[k]=1.
//     It works on a fixed maximum width. Callers zero-extend their operands
//     and truncate the result, so DATA_W must not exceed MERGE_W.
// Optional feature macro used by the block: REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int NREGS_DEF  = 32;

  localparam int MERGE_W    = 512;
  localparam int MERGE_BE_W = MERGE_W / 8;

  function automatic logic [MERGE_W-1:0] byte_merge(
    input logic [MERGE_W-1:0]    old_val,
    input logic [MERGE_W-1:0]    new_val,
    input logic [MERGE_BE_W-1:0] be
  );
    logic [MERGE_W-1:0] res;
    res = old_val;
    for (int k = 0; k < MERGE_BE_W; k++) begin
      if (be[k]) res[k*8 +: 8] = new_val[k*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits for regfile_sb.
// Ports:
//   clk, rst            : clock, async active-high reset
//   wr_en, wr_addr      : write-back port (a write clears the pending bit)
//   rsv_en, rsv_addr    : reservation request (sets the pending bit)
//   rd_addr_a/b         : read addresses for the busy lookups
//   busy_a/b            : read register has a pending write
//   rsv_stall           : reservation refused this cycle
//   pend_cnt            : registered popcount of the pending bits
// Macro REGFILE_BYPASS_EN: a read port whose address is being written this
// cycle reports busy=0, even if the same cycle re-reserves that register.
module regfile_scoreboard #(
  parameter  int NREGS  = 32,
  localparam int ADDR_W = $clog2(NREGS),
  localparam int CNT_W  = $clog2(NREGS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              busy_a,
  output logic              busy_b,
  output logic              rsv_stall,
  output logic [CNT_W-1:0]  pend_cnt
);

  logic [NREGS-1:0] pending_q, pending_d;
  logic [CNT_W-1:0] pend_cnt_q, pend_cnt_d;
  logic             wr_act;
  logic             rsv_act;

  assign wr_act = wr_en && (wr_addr != '0);

  // A write to the same register releases the old reservation in this same
  // cycle, so the new reservation is accepted rather than stalled.
  assign rsv_stall = rsv_en && (rsv_addr != '0) && pending_q[rsv_addr] &&
                     !(wr_en && (wr_addr == rsv_addr));
  assign rsv_act   = rsv_en && (rsv_addr != '0) && !rsv_stall;

  always_comb begin
    pending_d = pending_q;
    // Clear first, then set: a same-cycle reservation wins over the write.
    if (wr_act)  pending_d[wr_addr]  = 1'b0;
    if (rsv_act) pending_d[rsv_addr] = 1'b1;
    pending_d[0] = 1'b0;

    pend_cnt_d = '0;
    for (int i = 1; i < NREGS; i++) begin
      pend_cnt_d = pend_cnt_d + CNT_W'(pending_d[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q  <= '0;
      pend_cnt_q <= '0;
    end else begin
      pending_q  <= pending_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  always_comb begin
    busy_a = (rd_addr_a != '0) && pending_q[rd_addr_a];
    busy_b = (rd_addr_b != '0) && pending_q[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
    if (wr_act && (wr_addr == rd_addr_a)) busy_a = 1'b0;
    if (wr_act && (wr_addr == rd_addr_b)) busy_b = 1'b0;
`endif
  end

  assign pend_cnt = pend_cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: register file with byte-enabled write-back and a pending-write
// scoreboard. Register 0 is hard-wired to zero.
// Ports:
//   clk, rst                     : clock, async active-high reset
//   rd_addr_a/b -> rd_data_a/b   : combinational read ports
//   busy_a/b                     : read register has a pending write
//   wr_en, wr_addr, wr_data, wr_be : write-back port (byte enables)
//   rsv_en, rsv_addr             : reserve a destination register
//   rsv_stall                    : reservation refused this cycle
//   pend_cnt                     : count of pending registers
// Macro REGFILE_BYPASS_EN: a read of the register being written this cycle
// returns the byte-merged new value instead of the stored value.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int NREGS  = NREGS_DEF,
  localparam int ADDR_W = $clog2(NREGS),
  localparam int BE_W   = DATA_W / 8,
  localparam int CNT_W  = $clog2(NREGS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              busy_a,
  output logic              busy_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BE_W-1:0]   wr_be,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_stall,
  output logic [CNT_W-1:0]  pend_cnt
);

  logic [DATA_W-1:0] mem_q [NREGS];
  logic [DATA_W-1:0] mem_d [NREGS];
  logic              wr_act;
  logic [DATA_W-1:0] wr_merged;

  assign wr_act    = wr_en && (wr_addr != '0);
  assign wr_merged = DATA_W'(byte_merge(MERGE_W'(mem_q[wr_addr]),
                                        MERGE_W'(wr_data),
                                        MERGE_BE_W'(wr_be)));

  always_comb begin
    mem_d = mem_q;
    if (wr_act) mem_d[wr_addr] = wr_merged;
  end

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= mem_d[i];
    end
  end

  always_comb begin
    rd_data_a = mem_q[rd_addr_a];
    rd_data_b = mem_q[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
    // Writes are ignored during reset, so they are not forwarded either.
    if (!rst && wr_act && (wr_addr == rd_addr_a)) rd_data_a = wr_merged;
    if (!rst && wr_act && (wr_addr == rd_addr_b)) rd_data_b = wr_merged;
`endif
  end

  regfile_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .busy_a    (busy_a),
    .busy_b    (busy_b),
    .rsv_stall (rsv_stall),
    .pend_cnt  (pend_cnt)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed bench for regfile_sb with default parameters
// (DATA_W=32, NREGS=32). Follows REGFILE_BYPASS_EN when it is defined.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd_addr_a, rd_addr_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic        busy_a, busy_b;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        rsv_stall;
  logic [5:0]  pend_cnt;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .busy_a    (busy_a),
    .busy_b    (busy_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_be     (wr_be),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .rsv_stall (rsv_stall),
    .pend_cnt  (pend_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    rsv_en = 1'b0; rsv_addr = '0;
  endtask

  // Inputs are driven 1 time unit after a rising edge; this advances to the
  // next rising edge and returns with inputs idle, 1 unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    tick();
  endtask

  task automatic do_reserve(input logic [4:0] a);
    rsv_en = 1'b1; rsv_addr = a;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    rd_addr_a = 5'd5; rd_addr_b = 5'd7;
    idle_inputs();
    #1;
    check("reset_rd_a",    rd_data_a, 32'h0);
    check("reset_rd_b",    rd_data_b, 32'h0);
    check("reset_busy_a",  busy_a,    1'b0);
    check("reset_pend",    pend_cnt,  6'd0);
    check("reset_stall",   rsv_stall, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Full-word write, then read back; register 0 ignores writes.
    do_write(5'd5, 32'hDEADBEEF, 4'hF);
    rd_addr_a = 5'd5;
    #1 check("wr5_rd_a", rd_data_a, 32'hDEADBEEF);
    do_write(5'd0, 32'h12345678, 4'hF);
    rd_addr_a = 5'd0;
    #1 check("wr0_rd_a", rd_data_a, 32'h0);
    check("wr0_busy_a", busy_a, 1'b0);

    // Byte-lane merge.
    do_write(5'd7, 32'hAABBCCDD, 4'hF);
    do_write(5'd7, 32'h11223344, 4'h5);
    rd_addr_b = 5'd7;
    #1 check("merge_rd_b", rd_data_b, 32'hAA22CC44);
    check("nonpend_wr_pend", pend_cnt, 6'd0);

    // Reservations, stall on re-reserve, release on write.
    do_reserve(5'd3);
    do_reserve(5'd9);
    rd_addr_a = 5'd3; rd_addr_b = 5'd9;
    #1 check("rsv2_pend", pend_cnt, 6'd2);
    check("rsv3_busy_a", busy_a, 1'b1);
    check("rsv9_busy_b", busy_b, 1'b1);
    rsv_en = 1'b1; rsv_addr = 5'd3;
    #1 check("rerSV3_stall", rsv_stall, 1'b1);
    tick();
    check("stall_pend", pend_cnt, 6'd2);
    rsv_en = 1'b1; rsv_addr = 5'd0;
    #1 check("rsv0_stall", rsv_stall, 1'b0);
    tick();
    check("rsv0_pend", pend_cnt, 6'd2);
    do_write(5'd3, 32'h00000033, 4'hF);
    check("wr3_pend", pend_cnt, 6'd1);
    check("wr3_busy_a", busy_a, 1'b0);

    // Same-cycle write and reservation of a pending register.
    do_reserve(5'd4);
    check("rsv4_pend", pend_cnt, 6'd2);
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h00000044; wr_be = 4'hF;
    rsv_en = 1'b1; rsv_addr = 5'd4;
    #1 check("wr_rsv4_stall", rsv_stall, 1'b0);
    tick();
    rd_addr_a = 5'd4;
    #1 check("wr_rsv4_pend", pend_cnt, 6'd2);
    check("wr_rsv4_busy_a", busy_a, 1'b1);
    check("wr_rsv4_rd_a", rd_data_a, 32'h00000044);

    // Same-cycle write and read of register 6 (pending, stored value 0).
    do_reserve(5'd6);
    check("rsv6_pend", pend_cnt, 6'd3);
    wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'hCAFEF00D; wr_be = 4'hF;
    rd_addr_a = 5'd6;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_rd_a",   rd_data_a, 32'hCAFEF00D);
    check("byp_busy_a", busy_a,    1'b0);
`else
    check("nobyp_rd_a",   rd_data_a, 32'h0);
    check("nobyp_busy_a", busy_a,    1'b1);
`endif
    tick();
    check("wr6_rd_a", rd_data_a, 32'hCAFEF00D);
    check("wr6_pend", pend_cnt,  6'd2);

    // Asynchronous reset mid-cycle with three pending registers.
    do_reserve(5'd10);
    rd_addr_a = 5'd5; rd_addr_b = 5'd9;
    #1 check("pre_rst_pend", pend_cnt, 6'd3);
    check("pre_rst_busy_b", busy_b, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_rd_a",   rd_data_a, 32'h0);
    check("async_rst_busy_b", busy_b,    1'b0);
    check("async_rst_pend",   pend_cnt,  6'd0);
    // Writes and reservations are ignored while reset is held.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h55555555; wr_be = 4'hF;
    rsv_en = 1'b1; rsv_addr = 5'd9;
    @(posedge clk);
    #1;
    idle_inputs();
    check("in_rst_rd_a",   rd_data_a, 32'h0);
    check("in_rst_busy_b", busy_b,    1'b0);
    check("in_rst_pend",   pend_cnt,  6'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_rd_a", rd_data_a, 32'h0);
    check("post_rst_pend", pend_cnt,  6'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
